xor_chain_decoder: RTL and testbench

Receive-side companion to the XOR/invert correctness chain (IO_PAIRS parallel pairs, DEPTH serial stages). The block takes the chain's response word, undoes the DEPTH stages one per clock, and returns the recovered stimulus. It compares the recovered word against the reference stimulus and keeps running word and error counts. It sits between the bench/host stimulus path and the result logger, using valid/ready handshakes on both sides.

---
 rtl/xor_chain_decoder.sv | 151 +++++++++++++++
 tb/tb_xor_chain_decoder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_chain_decoder.sv
// xor_chain_decoder: receive side of the XOR/invert correctness chain.
// Accepts one chain response word, peels off DEPTH inverse stages (one per
// clock), presents the recovered stimulus together with a match flag against
// the captured reference, and keeps saturating word/error counters.
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid and ready are both high. s_ready is high only in IDLE. m_valid is
// high only in HOLD, where m_data/m_match stay frozen until m_ready.
module xor_chain_decoder #(
    parameter  int IO_PAIRS = 2,
    parameter  int DEPTH    = 1,
    parameter  int CNT_W    = 16,
    localparam int W        = 2 * IO_PAIRS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_data,
    input  logic [W-1:0]     s_ref,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W-1:0]     m_data,
    output logic             m_match,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] err_count,
    output logic             busy
);

    // Stage counter only needs to reach DEPTH-1; keep at least one bit.
    localparam int SCW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SCW-1:0] LAST_STAGE = SCW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UNWIND = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       work_q, work_d;
    logic [W-1:0]       ref_q, ref_d;
    logic [SCW-1:0]     stage_cnt_q, stage_cnt_d;
    logic [W-1:0]       m_data_q, m_data_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [W-1:0]       work_next;

    // One inverse stage: every pair updated from its pre-update value.
    function automatic logic [W-1:0] inv_stage(input logic [W-1:0] w);
        logic [W-1:0] r;
        r = w;
        for (int j = 0; j < IO_PAIRS; j++) begin
            r[2*j]   = ~w[2*j];
            r[2*j+1] = w[2*j+1] ^ ~w[2*j];
        end
        return r;
    endfunction

    // Saturating increment shared by both counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    // Result of applying the next stage to the current work word.
    always_comb begin
        work_next = inv_stage(work_q);
    end

    // Next-state logic for the FSM, datapath and counters.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        ref_d       = ref_q;
        stage_cnt_d = stage_cnt_q;
        m_data_d    = m_data_q;
        match_d     = match_q;
        word_cnt_d  = word_cnt_q;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    work_d      = s_data;
                    ref_d       = s_ref;
                    stage_cnt_d = '0;
                    state_d     = UNWIND;
                end
            end
            UNWIND: begin
                work_d      = work_next;
                stage_cnt_d = stage_cnt_q + SCW'(1);
                if (stage_cnt_q == LAST_STAGE) begin
                    // Output register is loaded only here so m_data keeps
                    // the previous word while a new one is being unwound.
                    m_data_d = work_next;
                    match_d  = (work_next == ref_q);
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (m_ready) begin
                    word_cnt_d = sat_inc(word_cnt_q);
                    if (!match_q) begin
                        err_cnt_d = sat_inc(err_cnt_q);
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            work_q      <= '0;
            ref_q       <= '0;
            stage_cnt_q <= '0;
            m_data_q    <= '0;
            match_q     <= 1'b0;
            word_cnt_q  <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            ref_q       <= ref_d;
            stage_cnt_q <= stage_cnt_d;
            m_data_q    <= m_data_d;
            match_q     <= match_d;
            word_cnt_q  <= word_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Output decode straight from the state register.
    always_comb begin
        s_ready    = (state_q == IDLE);
        m_valid    = (state_q == HOLD);
        busy       = (state_q != IDLE);
        m_data     = m_data_q;
        m_match    = match_q & (state_q == HOLD);
        word_count = word_cnt_q;
        err_count  = err_cnt_q;
    end

endmodule

// File: tb/tb_xor_chain_decoder.sv
// Bench for xor_chain_decoder: four instances (DEPTH 1/2/3 and a 2-bit
// counter variant) checked every cycle against a transaction-level model,
// plus directed vectors with hand-computed results.
module tb_xor_chain_decoder;

    localparam int W  = 4;
    localparam int NI = 4;
    localparam int DEP  [NI] = '{1, 2, 3, 1};
    localparam int CMAX [NI] = '{65535, 65535, 65535, 3};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst     [NI];
    logic         s_valid [NI];
    logic         m_ready [NI];
    logic [W-1:0] s_data  [NI];
    logic [W-1:0] s_ref   [NI];

    logic         s_ready_w [NI];
    logic         m_valid_w [NI];
    logic         m_match_w [NI];
    logic         busy_w    [NI];
    logic [W-1:0] m_data_w  [NI];
    logic [15:0]  wc_w      [NI];
    logic [15:0]  ec_w      [NI];
    logic [1:0]   wc_small, ec_small;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    xor_chain_decoder #(.IO_PAIRS(2), .DEPTH(1), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst[0]), .s_valid(s_valid[0]), .s_ready(s_ready_w[0]),
        .s_data(s_data[0]), .s_ref(s_ref[0]), .m_valid(m_valid_w[0]),
        .m_ready(m_ready[0]), .m_data(m_data_w[0]), .m_match(m_match_w[0]),
        .word_count(wc_w[0]), .err_count(ec_w[0]), .busy(busy_w[0]));

    xor_chain_decoder #(.IO_PAIRS(2), .DEPTH(2), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst[1]), .s_valid(s_valid[1]), .s_ready(s_ready_w[1]),
        .s_data(s_data[1]), .s_ref(s_ref[1]), .m_valid(m_valid_w[1]),
        .m_ready(m_ready[1]), .m_data(m_data_w[1]), .m_match(m_match_w[1]),
        .word_count(wc_w[1]), .err_count(ec_w[1]), .busy(busy_w[1]));

    xor_chain_decoder #(.IO_PAIRS(2), .DEPTH(3), .CNT_W(16)) dut2 (
        .clk(clk), .rst(rst[2]), .s_valid(s_valid[2]), .s_ready(s_ready_w[2]),
        .s_data(s_data[2]), .s_ref(s_ref[2]), .m_valid(m_valid_w[2]),
        .m_ready(m_ready[2]), .m_data(m_data_w[2]), .m_match(m_match_w[2]),
        .word_count(wc_w[2]), .err_count(ec_w[2]), .busy(busy_w[2]));

    xor_chain_decoder #(.IO_PAIRS(2), .DEPTH(1), .CNT_W(2)) dut3 (
        .clk(clk), .rst(rst[3]), .s_valid(s_valid[3]), .s_ready(s_ready_w[3]),
        .s_data(s_data[3]), .s_ref(s_ref[3]), .m_valid(m_valid_w[3]),
        .m_ready(m_ready[3]), .m_data(m_data_w[3]), .m_match(m_match_w[3]),
        .word_count(wc_small), .err_count(ec_small), .busy(busy_w[3]));

    assign wc_w[3] = {14'd0, wc_small};
    assign ec_w[3] = {14'd0, ec_small};

    // ---------------- behavioural model ----------------
    // One inverse stage maps each 2-bit pair p to (p-1) mod 4, so undoing
    // n stages is subtracting n from every pair.
    function automatic logic [W-1:0] model_inv(input logic [W-1:0] d, input int n);
        logic [W-1:0] r;
        for (int j = 0; j < W / 2; j++) begin
            r[2*j +: 2] = 2'(int'(d[2*j +: 2]) - n);
        end
        return r;
    endfunction

    bit           pend     [NI];
    int           age      [NI];
    logic [W-1:0] exp_d    [NI];
    logic         exp_m    [NI];
    logic [W-1:0] last_out [NI];
    int           wc_m     [NI];
    int           ec_m     [NI];

    initial begin
        for (int k = 0; k < NI; k++) begin
            pend[k] = 0; age[k] = 0; exp_d[k] = '0; exp_m[k] = 0;
            last_out[k] = '0; wc_m[k] = 0; ec_m[k] = 0;
        end
    end

    // Model timeline: accept, DEPTH cycles of unwinding, then hold until taken.
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rst[k]) begin
                pend[k] <= 0; age[k] <= 0; last_out[k] <= '0;
                wc_m[k] <= 0; ec_m[k] <= 0;
            end else if (!pend[k]) begin
                if (s_valid[k]) begin
                    pend[k]  <= 1;
                    age[k]   <= 0;
                    exp_d[k] <= model_inv(s_data[k], DEP[k]);
                    exp_m[k] <= (model_inv(s_data[k], DEP[k]) == s_ref[k]);
                end
            end else if (age[k] < DEP[k]) begin
                age[k] <= age[k] + 1;
                if (age[k] + 1 == DEP[k]) last_out[k] <= exp_d[k];
            end else if (m_ready[k]) begin
                pend[k] <= 0;
                if (wc_m[k] < CMAX[k]) wc_m[k] <= wc_m[k] + 1;
                if (!exp_m[k] && ec_m[k] < CMAX[k]) ec_m[k] <= ec_m[k] + 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input int k, input logic [15:0] act,
                       input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
        end
    endtask

    // Compare every output of every instance on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NI; k++) begin
                logic ev;
                ev = pend[k] && (age[k] == DEP[k]);
                chk("s_ready", k, 16'(s_ready_w[k]), 16'(!pend[k]));
                chk("m_valid", k, 16'(m_valid_w[k]), 16'(ev));
                chk("busy",    k, 16'(busy_w[k]),    16'(pend[k]));
                chk("m_data",  k, 16'(m_data_w[k]),  16'(last_out[k]));
                chk("m_match", k, 16'(m_match_w[k]), 16'(ev ? exp_m[k] : 1'b0));
                chk("word_count", k, wc_w[k], 16'(wc_m[k]));
                chk("err_count",  k, ec_w[k], 16'(ec_m[k]));
            end
        end
    end

    // ---------------- driver ----------------
    // Offer one word to an idle instance, wait for m_valid (bounded), hold
    // m_ready low for 'hold' cycles, then complete the output handshake.
    task automatic send_word(input int k, input logic [W-1:0] d, input logic [W-1:0] r,
                             input int hold, output logic [W-1:0] od,
                             output logic om, output int lat);
        s_data[k]  = d;
        s_ref[k]   = r;
        s_valid[k] = 1'b1;
        m_ready[k] = (hold == 0);
        @(posedge clk); #1;
        s_valid[k] = 1'b0;
        lat = 0;
        while (!m_valid_w[k] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("m_valid_timeout", k, 16'(m_valid_w[k]), 16'd1);
        od = m_data_w[k];
        om = m_match_w[k];
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            m_ready[k] = 1'b1;
        end
        @(posedge clk); #1;
        m_ready[k] = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [W-1:0] od;
        logic         om;
        int           lat;
        logic [15:0]  base;

        for (int k = 0; k < NI; k++) begin
            rst[k] = 1'b1; s_valid[k] = 1'b0; m_ready[k] = 1'b0;
            s_data[k] = '0; s_ref[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) rst[k] = 1'b0;
        chk_en = 1'b1;

        // Reset state
        chk("rst_s_ready", 0, 16'(s_ready_w[0]), 16'd1);
        chk("rst_m_valid", 0, 16'(m_valid_w[0]), 16'd0);
        chk("rst_m_data",  0, 16'(m_data_w[0]),  16'd0);
        chk("rst_wc",      0, wc_w[0], 16'd0);

        // 1: DEPTH=1, 1011 -> 0110, matching reference
        send_word(0, 4'b1011, 4'b0110, 0, od, om, lat);
        chk("t1_latency", 0, 16'(lat), 16'd1);
        chk("t1_data",    0, 16'(od),  16'b0110);
        chk("t1_match",   0, 16'(om),  16'd1);
        chk("t1_wc",      0, wc_w[0],  16'd1);
        chk("t1_ec",      0, ec_w[0],  16'd0);

        // 2: DEPTH=2, 1100 -> 1011 -> 0110
        send_word(1, 4'b1100, 4'b0110, 0, od, om, lat);
        chk("t2_latency", 1, 16'(lat), 16'd2);
        chk("t2_data",    1, 16'(od),  16'b0110);
        chk("t2_match",   1, 16'(om),  16'd1);

        // 3: DEPTH=1, mismatching reference
        send_word(0, 4'b1011, 4'b0000, 0, od, om, lat);
        chk("t3_data",  0, 16'(od), 16'b0110);
        chk("t3_match", 0, 16'(om), 16'd0);
        chk("t3_ec",    0, ec_w[0], 16'd1);
        chk("t3_wc",    0, wc_w[0], 16'd2);

        // 4a: backpressure for 5 cycles; 0001 -> 1100
        send_word(0, 4'b0001, 4'b1100, 5, od, om, lat);
        chk("t4_data",  0, 16'(od), 16'b1100);
        chk("t4_match", 0, 16'(om), 16'd1);
        chk("t4_wc",    0, wc_w[0], 16'd3);
        chk("t4_ec",    0, ec_w[0], 16'd1);

        // 4b: back-to-back on DEPTH=2, one word per 4 cycles
        base = wc_w[1];
        s_data[1] = 4'b1100; s_ref[1] = 4'b0110;
        s_valid[1] = 1'b1; m_ready[1] = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        s_valid[1] = 1'b0; m_ready[1] = 1'b0;
        chk("t4_b2b_words", 1, wc_w[1] - base, 16'd3);

        // 5: DEPTH=3 word delivered, then reset during UNWIND. 1010 -> 1111
        send_word(2, 4'b1010, 4'b1111, 0, od, om, lat);
        chk("t5_latency", 2, 16'(lat), 16'd3);
        chk("t5_data",    2, 16'(od),  16'b1111);
        chk("t5_wc",      2, wc_w[2],  16'd1);
        s_data[2] = 4'b0110; s_ref[2] = 4'b0000; s_valid[2] = 1'b1;
        @(posedge clk); #1;
        s_valid[2] = 1'b0;
        @(posedge clk); #1;
        rst[2] = 1'b1;
        @(posedge clk); #1;
        rst[2] = 1'b0;
        chk("t5_s_ready", 2, 16'(s_ready_w[2]), 16'd1);
        chk("t5_m_valid", 2, 16'(m_valid_w[2]), 16'd0);
        chk("t5_busy",    2, 16'(busy_w[2]),    16'd0);
        chk("t5_wc",      2, wc_w[2],           16'd0);
        m_ready[2] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        m_ready[2] = 1'b0;
        chk("t5_no_word", 2, 16'(m_valid_w[2]), 16'd0);
        chk("t5_wc_after", 2, wc_w[2], 16'd0);

        // 6: 2-bit counters saturate after 5 mismatching words
        for (int i = 0; i < 5; i++) begin
            send_word(3, 4'b1011, 4'b0000, 0, od, om, lat);
        end
        chk("t6_wc_sat", 3, wc_w[3], 16'd3);
        chk("t6_ec_sat", 3, ec_w[3], 16'd3);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
